// File: rtl/coin_pkg.sv
// Shared constants for the coin/selection pulse conditioner: channel indices,
// coin values, default timing parameters and the pending-selection record.
package coin_pkg;
  localparam int NI        = 0;
  localparam int DI        = 1;
  localparam int QU        = 2;
  localparam int SODA      = 3;
  localparam int DIET      = 4;
  localparam int NUM_CH    = 5;
  localparam int NUM_COINS = 3;

  localparam int NI_CENTS = 5;
  localparam int DI_CENTS = 10;
  localparam int QU_CENTS = 25;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_SYNC_STAGES     = 2;

  typedef struct packed {
    logic vld;
    logic diet;
  } sel_pend_t;

  function automatic logic [7:0] sat_add(logic [7:0] a, logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hff : s[7:0];
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// One input channel: flop synchronizer, stable-count debounce and a
// registered single-cycle rising-edge pulse of the debounced level.
module debounce_channel
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic CLK,
  input  logic rst,
  input  logic raw,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync;
  logic [7:0]             cnt;
  logic                   level;
  logic                   prev;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      prev  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      prev <= level;
      rise <= level & ~prev;
      // Any sample agreeing with the held level restarts the stability count.
      if (sync[SYNC_STAGES-1] == level) begin
        cnt <= '0;
      end else if (cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: rtl/coin_pulse_conditioner.sv
// Conditions raw coin/selection levels into arbitrated single-cycle pulses.
// Optional COIN_CREDIT_COUNT_EN adds a saturating credit_total output.
module coin_pulse_conditioner
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic CLK,
  input  logic rst,
  input  logic ni_raw,
  input  logic di_raw,
  input  logic qu_raw,
  input  logic soda_raw,
  input  logic diet_raw,
  output logic ni,
  output logic di,
  output logic qu,
  output logic soda,
  output logic diet,
  output logic coin_err,
  output logic sel_err
`ifdef COIN_CREDIT_COUNT_EN
  , output logic [7:0] credit_total
`endif
);
  logic [NUM_CH-1:0]    raw;
  logic [NUM_CH-1:0]    rise;
  logic [NUM_COINS-1:0] coin_rise, pend, cand, grant, pend_nxt;
  logic                 coin_drop, sel_both, sel_one, sel_drop, sel_go;
  sel_pend_t            sel_pend, sel_cand, sel_nxt;

  assign raw = {diet_raw, soda_raw, qu_raw, di_raw, ni_raw};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_ch (
      .CLK (CLK),
      .rst (rst),
      .raw (raw[g]),
      .rise(rise[g])
    );
  end

  assign coin_rise = rise[QU:NI];

  always_comb begin
    // New edges compete with pending coins so an uncontended coin goes out at once.
    cand  = pend | coin_rise;
    grant = '0;
    if (cand[QU])      grant[QU] = 1'b1;
    else if (cand[DI]) grant[DI] = 1'b1;
    else if (cand[NI]) grant[NI] = 1'b1;
    pend_nxt  = (cand & ~grant) | (pend & coin_rise & grant);
    coin_drop = |(pend & coin_rise & ~grant);

    sel_both = rise[SODA] & rise[DIET];
    sel_one  = rise[SODA] ^ rise[DIET];
    sel_drop = sel_both | (sel_one & sel_pend.vld);
    sel_cand = sel_pend;
    if (!sel_pend.vld && sel_one) begin
      sel_cand.vld  = 1'b1;
      sel_cand.diet = rise[DIET];
    end
    // A selection waits until no coin is pending or being issued.
    sel_go  = sel_cand.vld && (cand == '0);
    sel_nxt = sel_go ? '0 : sel_cand;
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      pend     <= '0;
      sel_pend <= '0;
      ni       <= 1'b0;
      di       <= 1'b0;
      qu       <= 1'b0;
      soda     <= 1'b0;
      diet     <= 1'b0;
      coin_err <= 1'b0;
      sel_err  <= 1'b0;
    end else begin
      pend     <= pend_nxt;
      sel_pend <= sel_nxt;
      ni       <= grant[NI];
      di       <= grant[DI];
      qu       <= grant[QU];
      soda     <= sel_go & ~sel_cand.diet;
      diet     <= sel_go & sel_cand.diet;
      coin_err <= coin_drop;
      sel_err  <= sel_drop;
    end
  end

`ifdef COIN_CREDIT_COUNT_EN
  logic [7:0] coin_val;

  always_comb begin
    coin_val = 8'd0;
    if (qu)      coin_val = 8'(QU_CENTS);
    else if (di) coin_val = 8'(DI_CENTS);
    else if (ni) coin_val = 8'(NI_CENTS);
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) credit_total <= '0;
    else      credit_total <= sat_add(credit_total, coin_val);
  end
`endif
endmodule
